ram_reader: RTL and testbench

RAM_READER -- requirements
Module: ram_reader

---
 rtl/ram_reader_pkg.sv | 23 ++
 rtl/ram_reader.sv | 126 ++++++++++++
 tb/tb_ram_reader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_reader_pkg
// Description : Shared types and default sizes for the RAM readout block.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_reader_pkg;

  // Default RAM geometry
  localparam int C_ADDR_W = 4;
  localparam int C_DATA_W = 8;

  // Readout sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_reader
// Description : Reads a block of consecutive RAM words and hands each one
//               downstream through a valid/ready handshake. One word is
//               fetched per ISSUE/CAPTURE/HOLD pass; addresses wrap modulo
//               the RAM size.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   c_rem_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [DATA_W-1:0]   r_dout;
  logic                w_load;
  logic                w_accept;

  // State register
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and state-decoded outputs; dout_ready only steers registers,
  // so no output depends combinationally on it
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    rd_en        = 1'b0;
    dout_valid   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            w_load       = 1'b1;
            w_next_state = ISSUE;
          end else begin
            w_next_state = DONE;
          end
        end
      end
      ISSUE: begin
        rd_en        = 1'b1;
        busy         = 1'b1;
        w_next_state = CAPTURE;
      end
      CAPTURE: begin
        busy         = 1'b1;
        w_next_state = HOLD;
      end
      HOLD: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
        if (dout_ready) begin
          w_accept     = 1'b1;
          w_next_state = (r_remaining == c_rem_one) ? DONE : ISSUE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Address and remaining-word counters; address rolls over naturally
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_load) begin
      r_addr      <= start_addr;
      r_remaining <= word_count;
    end else if (w_accept) begin
      r_addr      <= r_addr + c_addr_one;
      r_remaining <= r_remaining - c_rem_one;
    end
  end

  // Output word register, loaded only as CAPTURE closes
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
    end else if (r_state == CAPTURE) begin
      r_dout <= ram_q;
    end
  end

  assign rd_addr = r_addr;
  assign dout    = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_reader
// Description : Self-checking bench for ram_reader with a behavioural RAM
//               and a reference model built from word lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_reader;

  logic       clk_2;
  logic       reset;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] word_count;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] ram_q;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [16];

  logic [7:0] obs_dout [$];
  int         obs_addr [$];
  int         obs_acc_k [$];
  int         obs_done_k [$];
  int         first_valid_k;
  bit         busy_seen;
  bit         timed_out;

  ram_reader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .ram_q      (ram_q),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  // Synchronous-read RAM: data appears the cycle after rd_en
  always @(posedge clk_2) begin
    if (rd_en) ram_q <= mem[rd_addr];
  end

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Drive one readout and record what the DUT does; no checking here
  task automatic run_read(input int sa, input int cnt, input bit rnd, input bit now);
    int k;
    int tail;
    obs_dout.delete(); obs_addr.delete(); obs_acc_k.delete(); obs_done_k.delete();
    first_valid_k = -1; busy_seen = 0; timed_out = 0;
    k = 0; tail = -1;
    if (!now) @(negedge clk_2);
    start = 1'b1; start_addr = 4'(sa); word_count = 5'(cnt);
    forever begin
      @(negedge clk_2);
      k++;
      start = 1'b0;
      if (rd_en) obs_addr.push_back(int'(rd_addr));
      if (busy) busy_seen = 1;
      if (done) obs_done_k.push_back(k);
      dout_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (dout_valid && first_valid_k < 0) first_valid_k = k;
      if (dout_valid && dout_ready) begin
        obs_dout.push_back(dout);
        obs_acc_k.push_back(k);
      end
      if (done && tail < 0) tail = k + 3;
      if (k == tail) break;
      if (k >= 600) begin timed_out = 1; break; end
    end
    dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; start_addr = 4'd7; word_count = 5'd3; dout_ready = 1'b1;
    #1;
    checks++; if ({rd_en, rd_addr, dout, dout_valid, busy, done} !== 16'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {rd_en, rd_addr, dout, dout_valid, busy, done});
    end
    repeat (3) @(negedge clk_2);
    checks++; if ({rd_en, rd_addr, dout, dout_valid, busy, done} !== 16'h0) begin
      failures++; $display("FAIL reset_held got=%h exp=0", {rd_en, rd_addr, dout, dout_valid, busy, done});
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp[0] = 8'h10; exp[1] = 8'h20; exp[2] = 8'h30;
    fill_random();
    mem[2] = 8'h10; mem[3] = 8'h20; mem[4] = 8'h30;
    run_read(2, 3, 0, 0);
    checks++; if (obs_dout.size() !== 3) begin
      failures++; $display("FAIL basic_count got=%0d exp=3", obs_dout.size());
    end
    for (int i = 0; i < 3 && i < obs_dout.size(); i++) begin
      checks++; if (obs_dout[i] !== exp[i]) begin
        failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, obs_dout[i], exp[i]);
      end
      checks++; if (obs_acc_k[i] !== 3 * (i + 1)) begin
        failures++; $display("FAIL basic_timing[%0d] got=%0d exp=%0d", i, obs_acc_k[i], 3 * (i + 1));
      end
    end
    checks++; if (obs_done_k.size() !== 1 || obs_done_k[0] !== 10) begin
      failures++; $display("FAIL basic_done got_n=%0d exp_n=1 exp_k=10", obs_done_k.size());
    end
    checks++; if (dout !== 8'h30 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_idle_hold got=%h/%b/%b exp=30/0/0", dout, dout_valid, busy);
    end
  endtask

  task automatic test_zero_count();
    run_read(9, 0, 0, 0);
    checks++; if (obs_addr.size() !== 0) begin
      failures++; $display("FAIL zero_rd_en got=%0d exp=0", obs_addr.size());
    end
    checks++; if (obs_done_k.size() !== 1 || obs_done_k[0] !== 1) begin
      failures++; $display("FAIL zero_done got_n=%0d exp_n=1 exp_k=1", obs_done_k.size());
    end
    checks++; if (busy_seen !== 1'b0) begin
      failures++; $display("FAIL zero_busy got=%b exp=0", busy_seen);
    end
  endtask

  task automatic test_wrap();
    int exp_a [4];
    exp_a[0] = 14; exp_a[1] = 15; exp_a[2] = 0; exp_a[3] = 1;
    fill_random();
    run_read(14, 4, 0, 0);
    checks++; if (obs_addr.size() !== 4) begin
      failures++; $display("FAIL wrap_count got=%0d exp=4", obs_addr.size());
    end
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      checks++; if (obs_addr[i] !== exp_a[i]) begin
        failures++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, obs_addr[i], exp_a[i]);
      end
      checks++; if (i < obs_dout.size() && obs_dout[i] !== mem[exp_a[i]]) begin
        failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, obs_dout[i], mem[exp_a[i]]);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    @(negedge clk_2);
    start = 1'b1; start_addr = 4'd5; word_count = 5'd2; dout_ready = 1'b1;
    @(negedge clk_2); start = 1'b0;          // k=1, ISSUE, ready ignored
    @(negedge clk_2);                        // k=2, CAPTURE
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk_2);
      dout_ready = 1'b0;
      start = (k == 5); start_addr = 4'd12; word_count = 5'd9;
      checks++; if (dout_valid !== 1'b1 || dout !== mem[5]) begin
        failures++; $display("FAIL bp_stall_k%0d got=%b/%h exp=1/%h", k, dout_valid, dout, mem[5]);
      end
    end
    @(negedge clk_2);                        // k=8, still HOLD, accept now
    start = 1'b0; dout_ready = 1'b1;
    checks++; if (dout_valid !== 1'b1 || dout !== mem[5]) begin
      failures++; $display("FAIL bp_accept got=%b/%h exp=1/%h", dout_valid, dout, mem[5]);
    end
    @(negedge clk_2);                        // k=9, ISSUE for next word
    checks++; if (rd_en !== 1'b1 || rd_addr !== 4'd6) begin
      failures++; $display("FAIL bp_next_addr got=%b/%0d exp=1/6", rd_en, rd_addr);
    end
    repeat (2) @(negedge clk_2);             // k=11, HOLD
    checks++; if (dout_valid !== 1'b1 || dout !== mem[6]) begin
      failures++; $display("FAIL bp_word2 got=%b/%h exp=1/%h", dout_valid, dout, mem[6]);
    end
    @(negedge clk_2);                        // k=12, DONE
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_done got=%b/%b exp=1/0", done, busy);
    end
    @(negedge clk_2);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_after got=%b/%b exp=0/0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    @(negedge clk_2);
    start = 1'b1; start_addr = 4'd3; word_count = 5'd4; dout_ready = 1'b1;
    repeat (6) begin
      @(negedge clk_2);
      start = 1'b0;
    end
    checks++; if (dout_valid !== 1'b1 || dout !== mem[4]) begin
      failures++; $display("FAIL mid_second_hold got=%b/%h exp=1/%h", dout_valid, dout, mem[4]);
    end
    dout_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if ({rd_en, rd_addr, dout, dout_valid, busy, done} !== 16'h0) begin
      failures++; $display("FAIL mid_reset_now got=%h exp=0", {rd_en, rd_addr, dout, dout_valid, busy, done});
    end
    repeat (2) begin
      @(negedge clk_2);
      checks++; if (done !== 1'b0) begin
        failures++; $display("FAIL mid_no_done got=%b exp=0", done);
      end
    end
    reset = 1'b0;
    run_read(7, 3, 0, 1);
    checks++; if (first_valid_k !== 3) begin
      failures++; $display("FAIL mid_restart_latency got=%0d exp=3", first_valid_k);
    end
    checks++; if (obs_dout.size() !== 3 || obs_done_k.size() !== 1) begin
      failures++; $display("FAIL mid_restart_count got=%0d/%0d exp=3/1", obs_dout.size(), obs_done_k.size());
    end
    for (int i = 0; i < obs_dout.size() && i < 3; i++) begin
      checks++; if (obs_dout[i] !== mem[7 + i]) begin
        failures++; $display("FAIL mid_restart_data[%0d] got=%h exp=%h", i, obs_dout[i], mem[7 + i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int sa;
      int cnt;
      fill_random();
      sa  = $urandom_range(0, 15);
      cnt = (it == 0) ? 16 : $urandom_range(0, 16);
      run_read(sa, cnt, 1, 0);
      checks++; if (timed_out !== 1'b0 || obs_done_k.size() !== 1) begin
        failures++; $display("FAIL rnd%0d_done timeout=%b pulses=%0d exp=0/1", it, timed_out, obs_done_k.size());
      end
      checks++; if (obs_dout.size() !== cnt || obs_addr.size() !== cnt) begin
        failures++; $display("FAIL rnd%0d_count got=%0d/%0d exp=%0d", it, obs_dout.size(), obs_addr.size(), cnt);
      end
      for (int i = 0; i < cnt && i < obs_dout.size() && i < obs_addr.size(); i++) begin
        checks++; if (obs_addr[i] !== (sa + i) % 16 || obs_dout[i] !== mem[(sa + i) % 16]) begin
          failures++; $display("FAIL rnd%0d_word[%0d] got=%0d/%h exp=%0d/%h", it, i,
                               obs_addr[i], obs_dout[i], (sa + i) % 16, mem[(sa + i) % 16]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
